half_adder: RTL and testbench
=============================

// Module: half_adder
// PURPOSE
//   Bitwise half adder: sum = a XOR b, carry = a AND b, per bit lane.
//   Combinational sum/carry are the primary outputs and never wait on a clock.
//   A one-stage registered copy with valid qualifier serves pipelined consumers.
//   Leaf arithmetic primitive; full adders and small ripple adders are built from it.
// PARAMETERS
//   WIDTH  1  number of independent bit lanes; legal range 1..64
// PORTS
//   clk        in   1      single clock; all registers update on rising edge
//   rst        in   1      synchronous, active-high reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   in_valid   in   1      qualifies a/b for the registered stage
//   sum        out  WIDTH  combinational a ^ b
//   carry      out  WIDTH  combinational a & b
//   sum_q      out  WIDTH  registered sum
//   carry_q    out  WIDTH  registered carry
//   out_valid  out  1      sum_q/carry_q hold a newly captured result
// BEHAVIOUR
//   - sum/carry: pure combinational, zero latency, independent of clk, rst, in_valid.
//   - Truth table per lane (a,b -> sum,carry): 00->0,0 01->1,0 10->1,0 11->0,1.
//   - No carry propagates between lanes; the lanes are fully independent.
//   - Registered stage, rising clk:
//     - rst=1: sum_q=0, carry_q=0, out_valid=0. rst wins over in_valid.
//     - rst=0, in_valid=1: capture sum/carry; out_valid=1. Latency is 1 cycle.
//     - rst=0, in_valid=0: sum_q/carry_q hold; out_valid=0.
//   - Back-to-back in_valid gives one result per cycle. There is no backpressure.
//   - Reset asserted mid-stream drops the in-flight result. out_valid is 0 on the next edge.
//   - X/Z on a or b propagates; no masking.
// CONFIGURATION
//   - Macro HALF_ADDER_STATS_EN, when defined:
//     - Adds output carry_count [31:0].
//     - carry_count increments by 1 on each rising clk edge where rst=0, in_valid=1 and |carry=1.
//     - Saturates at 32'hFFFF_FFFF. Reset value 0.
//   - When not defined: no port, no counter logic. All other behaviour is identical.
// STRUCTURE
//   - Package half_adder_pkg:
//     - HA_MAX_WIDTH = 64.
//     - HA_CNT_W = 32.
//     - typedef ha_result_t {sum, carry} for the WIDTH=1 lane.
//   - Sub-module half_adder_cell: one lane, inputs a,b, outputs sum,carry.
//   - The top instantiates WIDTH cells in a generate loop, then adds the output register and the optional counter.
// TESTING
//   - Exhaustive WIDTH=1, no clock: all four a,b combinations, check after 10 ns.
//     a=0,b=0 -> 0/0; a=0,b=1 -> 1/0; a=1,b=0 -> 1/0; a=1,b=1 -> sum 0, carry 1.
//   - Reset: rst=1 for 2 cycles with a=1,b=1,in_valid=1 -> sum_q=0, carry_q=0, out_valid=0.
//     Combinational carry=1 throughout.
//   - Pipeline: WIDTH=8, in_valid=1.
//     a=8'hF0,b=8'h3C -> next edge sum_q=8'hCC, carry_q=8'h30, out_valid=1.
//     Then in_valid=0 -> values hold, out_valid=0.
//   - Lane independence: WIDTH=8, a=8'hFF,b=8'hFF -> sum=8'h00, carry=8'hFF.
//     No cross-lane effect.
//   - Reset mid-stream: rst=1 on the edge where in_valid=1 -> out_valid=0 and outputs 0 after that edge.
//   - HALF_ADDER_STATS_EN: 3 valid cycles, carries 1,0,1 -> carry_count=2.
//     A reset pulse returns carry_count to 0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants and the single-lane result type for the half adder family.
package half_adder_pkg;

  // Widest lane count the top is expected to be built with.
  localparam int unsigned HA_MAX_WIDTH = 64;

  // Width of the optional carry statistics counter.
  localparam int unsigned HA_CNT_W = 32;

  // Result of one lane: sum and carry of a single bit pair.
  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;

  // Evaluate one lane; X/Z on the operands propagates through ^ and &.
  function automatic ha_result_t ha_eval(input logic a, input logic b);
    ha_result_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// One half adder lane: sum = a ^ b, carry = a & b. Purely combinational.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  ha_result_t res;

  // Evaluate the lane and unpack the result onto the ports.
  always_comb begin
    res   = ha_eval(a, b);
    sum   = res.sum;
    carry = res.carry;
  end

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Bitwise half adder with combinational outputs plus a one-stage registered copy.
// Optional feature macro: HALF_ADDER_STATS_EN adds a saturating carry_count output
// counting accepted beats that produced at least one carry.
// WIDTH is expected to lie in 1..HA_MAX_WIDTH.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                in_valid,
  output logic [WIDTH-1:0]    sum,
  output logic [WIDTH-1:0]    carry,
  output logic [WIDTH-1:0]    sum_q,
  output logic [WIDTH-1:0]    carry_q,
`ifdef HALF_ADDER_STATS_EN
  output logic [HA_CNT_W-1:0] carry_count,
`endif
  output logic                out_valid
);

  // Independent lanes; no carry ever crosses from one lane into the next.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Next state of the output stage: capture on in_valid, otherwise hold data.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum;
      carry_d     = carry;
      out_valid_d = 1'b1;
    end
  end

  // Output register with synchronous reset; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

`ifdef HALF_ADDER_STATS_EN
  logic [HA_CNT_W-1:0] cnt_d;
  logic [HA_CNT_W-1:0] cnt_q;

  // Count accepted beats with any carry, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|carry) && (cnt_q != {HA_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`endif

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder (WIDTH=1 and WIDTH=8 instances).
// Build with +define+HALF_ADDER_STATS_EN to also exercise carry_count.
module tb_half_adder;
  import half_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, v1;
  logic       sum1, carry1, sum_q1, carry_q1, ov1;
  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] sum8, carry8, sum_q8, carry_q8;
  logic       ov8;
`ifdef HALF_ADDER_STATS_EN
  logic [HA_CNT_W-1:0] cnt1, cnt8;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .a           (a1),
    .b           (b1),
    .in_valid    (v1),
    .sum         (sum1),
    .carry       (carry1),
    .sum_q       (sum_q1),
    .carry_q     (carry_q1),
`ifdef HALF_ADDER_STATS_EN
    .carry_count (cnt1),
`endif
    .out_valid   (ov1)
  );

  half_adder #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .a           (a8),
    .b           (b8),
    .in_valid    (v8),
    .sum         (sum8),
    .carry       (carry8),
    .sum_q       (sum_q8),
    .carry_q     (carry_q8),
`ifdef HALF_ADDER_STATS_EN
    .carry_count (cnt8),
`endif
    .out_valid   (ov8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let one rising edge pass, then sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Truth table: {a,b} -> {sum,carry}
  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] tt_out [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;

    // Exhaustive combinational check, WIDTH=1, no dependence on clk.
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #10;
      chk($sformatf("comb_sum_%0d", i), {63'd0, sum1}, {63'd0, tt_out[i][1]});
      chk($sformatf("comb_carry_%0d", i), {63'd0, carry1}, {63'd0, tt_out[i][0]});
    end

    // Reset held two cycles with valid inputs present.
    @(negedge clk);
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      chk($sformatf("rst_sum_q_%0d", i), {63'd0, sum_q1}, 64'd0);
      chk($sformatf("rst_carry_q_%0d", i), {63'd0, carry_q1}, 64'd0);
      chk($sformatf("rst_out_valid_%0d", i), {63'd0, ov1}, 64'd0);
      chk($sformatf("rst_comb_carry_%0d", i), {63'd0, carry1}, 64'd1);
    end

    // Pipeline capture, WIDTH=8.
    rst = 1'b0;
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    #1;
    chk("pipe_comb_sum", {56'd0, sum8}, 64'hCC);
    chk("pipe_comb_carry", {56'd0, carry8}, 64'h30);
    next_cycle();
    chk("pipe_sum_q", {56'd0, sum_q8}, 64'hCC);
    chk("pipe_carry_q", {56'd0, carry_q8}, 64'h30);
    chk("pipe_out_valid", {63'd0, ov8}, 64'd1);
    chk("w1_sum_q", {63'd0, sum_q1}, 64'd0);
    chk("w1_carry_q", {63'd0, carry_q1}, 64'd1);
    chk("w1_out_valid", {63'd0, ov1}, 64'd1);

    // Drop in_valid: hold registered data; lane independence on all-ones operands.
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; v1 = 1'b0;
    #1;
    chk("lane_sum", {56'd0, sum8}, 64'h00);
    chk("lane_carry", {56'd0, carry8}, 64'hFF);
    next_cycle();
    chk("hold_sum_q", {56'd0, sum_q8}, 64'hCC);
    chk("hold_carry_q", {56'd0, carry_q8}, 64'h30);
    chk("hold_out_valid", {63'd0, ov8}, 64'd0);
    chk("w1_hold_valid", {63'd0, ov1}, 64'd0);

    // Back-to-back beats, one result per cycle.
    v8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
    next_cycle();
    chk("b2b0_sum_q", {56'd0, sum_q8}, 64'h0E);
    chk("b2b0_carry_q", {56'd0, carry_q8}, 64'h01);
    chk("b2b0_out_valid", {63'd0, ov8}, 64'd1);
    a8 = 8'hAA; b8 = 8'h55;
    next_cycle();
    chk("b2b1_sum_q", {56'd0, sum_q8}, 64'hFF);
    chk("b2b1_carry_q", {56'd0, carry_q8}, 64'h00);
    chk("b2b1_out_valid", {63'd0, ov8}, 64'd1);

    // Reset on an edge with in_valid high drops the beat.
    a8 = 8'hFF; b8 = 8'h01; rst = 1'b1;
    next_cycle();
    chk("midrst_sum_q", {56'd0, sum_q8}, 64'h00);
    chk("midrst_carry_q", {56'd0, carry_q8}, 64'h00);
    chk("midrst_out_valid", {63'd0, ov8}, 64'd0);
    rst = 1'b0; v8 = 1'b0;
    next_cycle();

`ifdef HALF_ADDER_STATS_EN
    // Three valid beats with carry present, absent, present -> count of 2.
    chk("stats_start", {32'd0, cnt8}, 64'd0);
    v8 = 1'b1;
    a8 = 8'h01; b8 = 8'h01;
    next_cycle();
    a8 = 8'h01; b8 = 8'h02;
    next_cycle();
    a8 = 8'h80; b8 = 8'h80;
    next_cycle();
    v8 = 1'b0;
    next_cycle();
    chk("stats_count", {32'd0, cnt8}, 64'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("stats_reset", {32'd0, cnt8}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_half_adder
